// File: rtl/rop_ba_mem_arb.sv
// Round-robin arbiter sharing one data-memory port between the CPU and the co-processor.
// Registered grant FSM; every output is a combinational function of state and the granted port.
module rop_ba_mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_mem_cen,
    input  logic                cpu_mem_wen,
    input  logic [DATA_W/8-1:0] cpu_mem_ben,
    input  logic [ADDR_W-1:0]   cpu_mem_addr,
    input  logic [DATA_W-1:0]   cpu_mem_wdata,
    output logic [DATA_W-1:0]   cpu_mem_rdata,
    output logic                cpu_mem_stall,
    output logic                cpu_mem_error,
    input  logic                cop_mem_cen,
    input  logic                cop_mem_wen,
    input  logic [DATA_W/8-1:0] cop_mem_ben,
    input  logic [ADDR_W-1:0]   cop_mem_addr,
    input  logic [DATA_W-1:0]   cop_mem_wdata,
    output logic [DATA_W-1:0]   cop_mem_rdata,
    output logic                cop_mem_stall,
    output logic                cop_mem_error,
    output logic                mem_cen,
    output logic                mem_wen,
    output logic [DATA_W/8-1:0] mem_ben,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_stall,
    input  logic                mem_error,
    output logic [1:0]          arb_gnt
);

    typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_COP} state_t;

    localparam logic LAST_CPU = 1'b0;
    localparam logic LAST_COP = 1'b1;

    state_t state, state_n;
    logic   last, last_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= LAST_COP;  // CPU wins the first tie
        end else begin
            state <= state_n;
            last  <= last_n;
        end
    end

    always_comb begin
        state_n       = state;
        last_n        = last;
        mem_cen       = 1'b0;
        mem_wen       = 1'b0;
        mem_ben       = '0;
        mem_addr      = '0;
        mem_wdata     = '0;
        cpu_mem_rdata = '0;
        cpu_mem_error = 1'b0;
        cpu_mem_stall = cpu_mem_cen;
        cop_mem_rdata = '0;
        cop_mem_error = 1'b0;
        cop_mem_stall = cop_mem_cen;
        arb_gnt       = 2'b00;

        case (state)
            IDLE: begin
                if (cpu_mem_cen && (!cop_mem_cen || last == LAST_COP))
                    state_n = GNT_CPU;
                else if (cop_mem_cen)
                    state_n = GNT_COP;
            end
            GNT_CPU: begin
                arb_gnt       = 2'b01;
                mem_cen       = cpu_mem_cen;
                mem_wen       = cpu_mem_wen;
                mem_ben       = cpu_mem_ben;
                mem_addr      = cpu_mem_addr;
                mem_wdata     = cpu_mem_wdata;
                cpu_mem_rdata = mem_rdata;
                cpu_mem_stall = mem_stall;
                cpu_mem_error = mem_error;
                // Staying granted after a completion lets a follow-on request go without a bubble
                if (cpu_mem_cen) begin
                    if (!mem_stall) begin
                        last_n = LAST_CPU;
                        if (cop_mem_cen) state_n = GNT_COP;
                    end
                end else begin
                    state_n = cop_mem_cen ? GNT_COP : IDLE;
                end
            end
            GNT_COP: begin
                arb_gnt       = 2'b10;
                mem_cen       = cop_mem_cen;
                mem_wen       = cop_mem_wen;
                mem_ben       = cop_mem_ben;
                mem_addr      = cop_mem_addr;
                mem_wdata     = cop_mem_wdata;
                cop_mem_rdata = mem_rdata;
                cop_mem_stall = mem_stall;
                cop_mem_error = mem_error;
                if (cop_mem_cen) begin
                    if (!mem_stall) begin
                        last_n = LAST_COP;
                        if (cpu_mem_cen) state_n = GNT_CPU;
                    end
                end else begin
                    state_n = cpu_mem_cen ? GNT_CPU : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rop_ba_mem_arb.sv
// Directed bench for rop_ba_mem_arb: per-port scoreboards checked on each downstream completion,
// plus grant/stall checks at every directed step.
module tb_rop_ba_mem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mem_cen, cpu_mem_wen;
    logic [3:0]  cpu_mem_ben;
    logic [31:0] cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
    logic        cpu_mem_stall, cpu_mem_error;
    logic        cop_mem_cen, cop_mem_wen;
    logic [3:0]  cop_mem_ben;
    logic [31:0] cop_mem_addr, cop_mem_wdata, cop_mem_rdata;
    logic        cop_mem_stall, cop_mem_error;
    logic        mem_cen, mem_wen;
    logic [3:0]  mem_ben;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_stall, mem_error;
    logic [1:0]  arb_gnt;

    int checks = 0;
    int errors = 0;
    int cnt_cpu = 0;
    int cnt_cop = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  ben;
        logic [31:0] wdata;
        logic        err;
    } exp_t;

    exp_t q_cpu[$];
    exp_t q_cop[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hA5A5_0000;
    endfunction

    assign mem_rdata = rd_model(mem_addr);

    rop_ba_mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_mem_cen(cpu_mem_cen), .cpu_mem_wen(cpu_mem_wen), .cpu_mem_ben(cpu_mem_ben),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_rdata(cpu_mem_rdata),
        .cpu_mem_stall(cpu_mem_stall), .cpu_mem_error(cpu_mem_error),
        .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen), .cop_mem_ben(cop_mem_ben),
        .cop_mem_addr(cop_mem_addr), .cop_mem_wdata(cop_mem_wdata), .cop_mem_rdata(cop_mem_rdata),
        .cop_mem_stall(cop_mem_stall), .cop_mem_error(cop_mem_error),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_ben(mem_ben), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .mem_error(mem_error), .arb_gnt(arb_gnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every downstream completion is matched against the owner's queue.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && mem_cen === 1'b1 && mem_stall === 1'b0) begin
            if (arb_gnt === 2'b01) begin
                if (q_cpu.size() == 0) chk("cpu_unexpected", 32'd1, 32'd0);
                else begin
                    e = q_cpu.pop_front();
                    cnt_cpu++;
                    chk("cpu_addr", mem_addr, e.addr);
                    chk("cpu_wen", 32'(mem_wen), 32'(e.wen));
                    chk("cpu_ben", 32'(mem_ben), 32'(e.ben));
                    chk("cpu_wdata", mem_wdata, e.wdata);
                    chk("cpu_rdata", cpu_mem_rdata, rd_model(e.addr));
                    chk("cpu_stall_done", 32'(cpu_mem_stall), 32'd0);
                    chk("cpu_err", 32'(cpu_mem_error), 32'(e.err));
                    chk("cop_idle_rdata", cop_mem_rdata, 32'd0);
                    chk("cop_idle_err", 32'(cop_mem_error), 32'd0);
                    chk("cop_idle_stall", 32'(cop_mem_stall), 32'(cop_mem_cen));
                end
            end else if (arb_gnt === 2'b10) begin
                if (q_cop.size() == 0) chk("cop_unexpected", 32'd1, 32'd0);
                else begin
                    e = q_cop.pop_front();
                    cnt_cop++;
                    chk("cop_addr", mem_addr, e.addr);
                    chk("cop_wen", 32'(mem_wen), 32'(e.wen));
                    chk("cop_ben", 32'(mem_ben), 32'(e.ben));
                    chk("cop_wdata", mem_wdata, e.wdata);
                    chk("cop_rdata", cop_mem_rdata, rd_model(e.addr));
                    chk("cop_stall_done", 32'(cop_mem_stall), 32'd0);
                    chk("cop_err", 32'(cop_mem_error), 32'(e.err));
                    chk("cpu_idle_rdata", cpu_mem_rdata, 32'd0);
                    chk("cpu_idle_err", 32'(cpu_mem_error), 32'd0);
                    chk("cpu_idle_stall", 32'(cpu_mem_stall), 32'(cpu_mem_cen));
                end
            end else begin
                chk("gnt_at_completion", 32'(arb_gnt), 32'd3);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                           input logic [31:0] d, input logic err);
        exp_t e;
        cpu_mem_cen = 1'b1; cpu_mem_wen = w; cpu_mem_ben = b; cpu_mem_addr = a; cpu_mem_wdata = d;
        e.addr = a; e.wen = w; e.ben = b; e.wdata = d; e.err = err;
        q_cpu.push_back(e);
    endtask

    task automatic cop_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                           input logic [31:0] d, input logic err);
        exp_t e;
        cop_mem_cen = 1'b1; cop_mem_wen = w; cop_mem_ben = b; cop_mem_addr = a; cop_mem_wdata = d;
        e.addr = a; e.wen = w; e.ben = b; e.wdata = d; e.err = err;
        q_cop.push_back(e);
    endtask

    initial begin
        int base_cop;
        reset = 1'b1;
        cpu_mem_cen = 0; cpu_mem_wen = 0; cpu_mem_ben = 0; cpu_mem_addr = 0; cpu_mem_wdata = 0;
        cop_mem_cen = 0; cop_mem_wen = 0; cop_mem_ben = 0; cop_mem_addr = 0; cop_mem_wdata = 0;
        mem_stall = 0; mem_error = 0;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_gnt", 32'(arb_gnt), 32'd0);
        chk("rst_mem_cen", 32'(mem_cen), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_rdata", cpu_mem_rdata, 32'd0);
        chk("rst_cop_err", 32'(cop_mem_error), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_mem_stall), 32'd0);

        // Single CPU read
        cyc(); reset = 1'b0;
        cpu_req(32'h100, 1'b0, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        chk("t1_c0_gnt", 32'(arb_gnt), 32'd0);
        chk("t1_c0_stall", 32'(cpu_mem_stall), 32'd1);
        chk("t1_c0_mem_cen", 32'(mem_cen), 32'd0);
        cyc();
        @(negedge clk);
        chk("t1_c1_gnt", 32'(arb_gnt), 32'd1);
        chk("t1_c1_mem_cen", 32'(mem_cen), 32'd1);
        chk("t1_c1_addr", mem_addr, 32'h100);
        chk("t1_c1_stall", 32'(cpu_mem_stall), 32'd0);
        cyc(); cpu_mem_cen = 1'b0;
        @(negedge clk);
        chk("t1_drop_mem_cen", 32'(mem_cen), 32'd0);
        cyc();

        // Tie from reset: CPU first, then COP
        reset = 1'b1;
        cyc(); reset = 1'b0;
        cpu_req(32'h200, 1'b1, 4'h3, 32'hDEAD_0001, 1'b0);
        cop_req(32'h204, 1'b0, 4'hF, 32'h0, 1'b0);
        @(negedge clk); chk("t2_gnt0", 32'(arb_gnt), 32'd0);
        cyc();
        @(negedge clk); chk("t2_gnt1", 32'(arb_gnt), 32'd1);
        chk("t2_cop_stall", 32'(cop_mem_stall), 32'd1);
        cyc(); cpu_mem_cen = 1'b0;
        @(negedge clk); chk("t2_gnt2", 32'(arb_gnt), 32'd2);
        cyc(); cop_mem_cen = 1'b0;
        cyc();

        // Grant hold under stall
        mem_stall = 1'b1;
        cop_req(32'h300, 1'b1, 4'hC, 32'hC0C0_0300, 1'b0);
        @(negedge clk); chk("t3_idle_gnt", 32'(arb_gnt), 32'd0);
        cyc();
        cpu_req(32'h140, 1'b0, 4'hF, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_gnt", 32'(arb_gnt), 32'd2);
            chk("t3_cpu_stall", 32'(cpu_mem_stall), 32'd1);
            chk("t3_cpu_rdata", cpu_mem_rdata, 32'd0);
            chk("t3_cop_stall", 32'(cop_mem_stall), 32'd1);
            cyc();
        end
        mem_stall = 1'b0;
        @(negedge clk); chk("t3_cop_done_gnt", 32'(arb_gnt), 32'd2);
        cyc(); cop_mem_cen = 1'b0;
        @(negedge clk); chk("t3_cpu_gnt", 32'(arb_gnt), 32'd1);
        cyc(); cpu_mem_cen = 1'b0;
        cyc();

        // Back-to-back COP transfers
        base_cop = cnt_cop;
        cop_req(32'hA00, 1'b0, 4'hF, 32'h0, 1'b0);
        @(negedge clk); chk("t4_idle_gnt", 32'(arb_gnt), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k > 0) cop_req(32'hA00 + 32'(4 * k), k[0], 4'(k), 32'h1111_0000 + 32'(k), 1'b0);
            @(negedge clk);
            chk("t4_gnt", 32'(arb_gnt), 32'd2);
            chk("t4_mem_cen", 32'(mem_cen), 32'd1);
            chk("t4_addr", mem_addr, 32'hA00 + 32'(4 * k));
        end
        cyc(); cop_mem_cen = 1'b0;
        chk("t4_count", 32'(cnt_cop - base_cop), 32'd4);
        cyc();

        // Error routing and the following hand-over
        mem_error = 1'b1;
        cop_req(32'h400, 1'b0, 4'hF, 32'h0, 1'b1);
        @(negedge clk);
        chk("t5_idle_cop_err", 32'(cop_mem_error), 32'd0);
        chk("t5_idle_cpu_err", 32'(cpu_mem_error), 32'd0);
        cyc();
        cpu_req(32'h500, 1'b1, 4'h1, 32'h5555_AAAA, 1'b0);
        @(negedge clk);
        chk("t5_gnt", 32'(arb_gnt), 32'd2);
        chk("t5_cop_err", 32'(cop_mem_error), 32'd1);
        chk("t5_cpu_err", 32'(cpu_mem_error), 32'd0);
        cyc(); cop_mem_cen = 1'b0; mem_error = 1'b0;
        @(negedge clk);
        chk("t5_next_gnt", 32'(arb_gnt), 32'd1);
        cyc(); cpu_mem_cen = 1'b0;
        cyc();

        // Reset during a stalled CPU write
        mem_stall = 1'b1;
        cpu_req(32'h600, 1'b1, 4'hF, 32'h6666_6666, 1'b0);
        cyc();
        @(negedge clk);
        chk("t6_gnt", 32'(arb_gnt), 32'd1);
        chk("t6_mem_wen", 32'(mem_wen), 32'd1);
        cyc();
        reset = 1'b1;
        cop_req(32'h700, 1'b0, 4'hF, 32'h0, 1'b0);
        cyc();
        @(negedge clk);
        chk("t6_rst_mem_cen", 32'(mem_cen), 32'd0);
        chk("t6_rst_gnt", 32'(arb_gnt), 32'd0);
        chk("t6_rst_cpu_err", 32'(cpu_mem_error), 32'd0);
        cyc();
        reset = 1'b0; cpu_mem_cen = 1'b0; mem_stall = 1'b0;
        q_cpu.delete();
        @(negedge clk); chk("t6_rel_gnt", 32'(arb_gnt), 32'd0);
        cyc();
        @(negedge clk); chk("t6_cop_gnt", 32'(arb_gnt), 32'd2);
        cyc(); cop_mem_cen = 1'b0;
        cyc(); cyc();

        chk("total_cpu", 32'(cnt_cpu), 32'd4);
        chk("total_cop", 32'(cnt_cop), 32'd8);
        chk("q_cpu_empty", 32'(q_cpu.size()), 32'd0);
        chk("q_cop_empty", 32'(q_cop.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rop_ba_mem_arb.md
# rop_ba_mem_arb

Two-requester memory port arbiter that lets the CPU data port and the `rop_ba_cop` co-processor memory interface share one downstream memory port. A registered grant FSM picks an owner, forwards the owner's request to memory, and returns stall, error and read data only to the owner. The non-owner is held stalled. Arbitration is round-robin with zero-bubble hand-over between back-to-back transfers. It sits between the co-processor, the CPU core and the single-ported data memory.

## Interface
- `ADDR_W`, default 32, address width.
- `DATA_W`, default 32, data width. Byte-enable width is `DATA_W/8`.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cpu_mem_cen` in 1: CPU request (active high); held until its transfer completes.
- `cpu_mem_wen` in 1: CPU write (1) / read (0).
- `cpu_mem_ben` in `DATA_W/8`: CPU byte enables.
- `cpu_mem_addr` in `ADDR_W`: CPU address.
- `cpu_mem_wdata` in `DATA_W`: CPU write data.
- `cpu_mem_rdata` out `DATA_W`: CPU read data, valid on completion cycle.
- `cpu_mem_stall` out 1: CPU stall.
- `cpu_mem_error` out 1: CPU error, valid on completion cycle.
- `cop_mem_cen`, `cop_mem_wen`, `cop_mem_ben`, `cop_mem_addr`, `cop_mem_wdata` in; `cop_mem_rdata`, `cop_mem_stall`, `cop_mem_error` out: co-processor port, identical semantics to the CPU port.
- `mem_cen`, `mem_wen` out 1; `mem_ben` out `DATA_W/8`; `mem_addr` out `ADDR_W`; `mem_wdata` out `DATA_W`: downstream request.
- `mem_rdata` in `DATA_W`; `mem_stall` in 1; `mem_error` in 1: downstream response.
- `arb_gnt` out 2: one-hot owner. Bit 0 is CPU, bit 1 is COP. `2'b00` when idle.

## Operation
Port protocol, all three ports:
- A transfer completes on any cycle with `cen=1` and `stall=0`.
- `rdata` and `error` are meaningful only on that cycle.
- A requester must hold `cen` and its request fields stable until completion.

FSM states are IDLE, GNT_CPU and GNT_COP. A `last` register records the last owner served.
- **IDLE**
  - `mem_cen=0` and all `mem_*` request outputs are 0.
  - Each requester's `stall` equals its own `cen`.
  - Only CPU requesting: next state GNT_CPU. Only COP requesting: next state GNT_COP.
  - Both requesting: grant the requester that is not `last`.
  - Neither requesting: stay in IDLE.
- **GNT_x**
  - `mem_*` request outputs are a combinational mux of requester x.
  - x's `rdata` = `mem_rdata`, x's `stall` = `mem_stall`, x's `error` = `mem_error`.
  - The other requester sees `stall` = its `cen`, `rdata=0`, `error=0`.
- **Completion in GNT_x** (x `cen=1`, `mem_stall=0`):
  - `last` <= x.
  - If the other requester's `cen=1`, next state is GNT_other. Otherwise stay in GNT_x, so a new x request proceeds with no bubble.
- **GNT_x with x `cen=0`:** next state is GNT_other if the other requester's `cen=1`, else IDLE. `mem_cen=0` this cycle.
- **GNT_x with `mem_stall=1`:** stay in GNT_x. The grant never changes mid-transfer.
- **Errors:** `mem_error` is passed through unmodified and does not alter arbitration.

## Timing
- **Reset values:**
  - State IDLE, `last`=COP (so the CPU wins the first tie), `arb_gnt=2'b00`.
  - `mem_cen`, `mem_wen`, `mem_ben`, `mem_addr` and `mem_wdata` are 0.
  - Both `rdata` outputs are 0 and both `error` outputs are 0.
  - Each port's `stall` equals its `cen`.
- **Latency from IDLE:** one cycle of arbitration. The request appears on `mem_*` in the cycle after `cen` rises.
- **Throughput:** back-to-back transfers, same owner or alternating, need no idle cycle.
- **Output paths:** all outputs are combinational from state plus the granted port. The only registers are the state and `last`.
- **Reset mid-transfer:** the FSM returns to IDLE on the next edge. `mem_cen=0` from that edge and the in-flight transfer is abandoned. No error is reported.
- **Simultaneous events:** completion by x in the same cycle the other requester raises `cen` hands over on the next edge. Both requesters rising in IDLE together resolve by `last`.

## Test plan
- **Single CPU read, `mem_stall=0`:** CPU `cen` at cycle 0 with addr `0x100` -> `mem_cen=1`, `mem_addr=0x100` at cycle 1. `cpu_mem_stall` is 1 at cycle 0 and 0 at cycle 1. `arb_gnt=01` at cycle 1.
- **Tie from reset:** both raise `cen` at cycle 0 -> CPU granted at cycle 1 and COP at cycle 2. `arb_gnt` sequence is `00,01,10`.
- **Grant hold under stall:** COP owns the port, `mem_stall=1` for 3 cycles, CPU requests meanwhile -> `arb_gnt` stays `10` for all 3 cycles. CPU `stall=1` and `rdata=0` throughout. CPU is granted on the edge after COP completes.
- **Back-to-back:** COP issues 4 transfers with `cen` continuously high, `mem_stall=0` -> 4 completions in 4 consecutive cycles with no IDLE cycle.
- **Error routing:** `mem_error=1` on a COP completion -> `cop_mem_error=1` and `cpu_mem_error=0`. The next arbitration is unaffected.
- **Reset mid-transfer:** assert `reset` during a stalled CPU write -> `mem_cen=0` and `arb_gnt=00` on the next edge. After release, a pending COP request is granted within one cycle.
